// File: rtl/pdm_demod.sv
// PDM microphone receiver: drives the mic bit clock, samples the 1-bit stream and
// decimates it with a boxcar filter into signed 8-bit PCM samples.
module pdm_demod #(
    parameter int CLK_DIV  = 32,
    parameter int DEC_LOG2 = 6
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              en_in,
    input  logic              pdm_in,
    output logic              mic_clk_out,
    output logic signed [7:0] sample_out,
    output logic              sample_valid_out
);
    localparam int CW  = $clog2(CLK_DIV);
    localparam int SHL = (DEC_LOG2 <= 7) ? 7 - DEC_LOG2 : 0;
    localparam int SHR = (DEC_LOG2 > 7) ? DEC_LOG2 - 7 : 0;
    localparam logic [CW-1:0]       CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]       CNT_HALF = CW'(CLK_DIV / 2);
    localparam logic [DEC_LOG2-1:0] BIT_LAST = '1;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic                mic_clk_q;
    logic [1:0]          sync_q;
    logic [DEC_LOG2-1:0] bit_cnt_q;
    logic [DEC_LOG2:0]   acc_q, ones;
    logic                warm_q;
    logic signed [7:0]   sample_q, sample_sat;
    logic                valid_q;
    logic                tick, win_end;
    logic signed [15:0]  centered, scaled;

    always_comb begin
        tick     = (cnt_q == CNT_LAST);
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        win_end  = tick && (bit_cnt_q == BIT_LAST);
        // The closing bit is folded in here so it counts toward the window it ends.
        ones     = acc_q + {{DEC_LOG2{1'b0}}, sync_q[1]};
        centered = $signed((16'(ones) << 1) - (16'd1 << DEC_LOG2));
        scaled   = (centered <<< SHL) >>> SHR;
        if (scaled > 16'sd127) begin
            sample_sat = 8'sd127;
        end else if (scaled < -16'sd128) begin
            sample_sat = -8'sd128;
        end else begin
            sample_sat = scaled[7:0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in || !en_in) begin
            cnt_q     <= '0;
            mic_clk_q <= 1'b0;
            sync_q    <= '0;
            bit_cnt_q <= '0;
            acc_q     <= '0;
            warm_q    <= 1'b0;
            valid_q   <= 1'b0;
            // Disable alone keeps the last sample; only reset clears it.
            if (!rst_in) begin
                sample_q <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            mic_clk_q <= (cnt_d >= CNT_HALF);
            sync_q    <= {sync_q[0], pdm_in};
            valid_q   <= 1'b0;
            if (tick) begin
                if (win_end) begin
                    acc_q     <= '0;
                    bit_cnt_q <= '0;
                    warm_q    <= 1'b1;
                    // The first full window after start-up is discarded.
                    if (warm_q) begin
                        sample_q <= sample_sat;
                        valid_q  <= 1'b1;
                    end
                end else begin
                    acc_q     <= ones;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end
        end
    end

    assign mic_clk_out      = mic_clk_q;
    assign sample_out       = sample_q;
    assign sample_valid_out = valid_q;
endmodule

// File: tb/tb_pdm_demod.sv
// Self-checking bench for pdm_demod: a window model pushes expected samples and
// strobe times to a queue; a negedge monitor pops and compares on each strobe.
module tb_pdm_demod;
    localparam int CLK_DIV = 4;
    localparam int DEC     = 6;
    localparam int WIN     = 1 << DEC;

    logic clk = 1'b0;
    logic rst_n, en, en8, pdm;
    logic mic, valid, mic8, valid8;
    logic signed [7:0] sample, sample8;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int strobes8 = 0;

    typedef struct {
        logic signed [31:0] val;
        int                 at;
    } exp_t;
    exp_t q[$];
    exp_t e;

    int m_acc, m_bits;
    bit m_warm;
    logic signed [31:0] last;

    pdm_demod #(.CLK_DIV(CLK_DIV), .DEC_LOG2(DEC)) dut (
        .clk_in(clk), .rst_in(rst_n), .en_in(en), .pdm_in(pdm),
        .mic_clk_out(mic), .sample_out(sample), .sample_valid_out(valid)
    );

    pdm_demod #(.CLK_DIV(CLK_DIV), .DEC_LOG2(8)) dut8 (
        .clk_in(clk), .rst_in(rst_n), .en_in(en8), .pdm_in(pdm),
        .mic_clk_out(mic8), .sample_out(sample8), .sample_valid_out(valid8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] want);
        checks++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic logic signed [31:0] conv(input int ones, input int dec);
        int c;
        c = 2 * ones - (1 << dec);
        if (dec <= 7) c = c * (1 << (7 - dec));
        else c = c >>> (dec - 7);
        if (c > 127) c = 127;
        if (c < -128) c = -128;
        return c;
    endfunction

    task automatic model_reset();
        m_acc = 0;
        m_bits = 0;
        m_warm = 1'b0;
    endtask

    // Drives one bit for the next tick and checks the bit clock over its period.
    task automatic send_bit(input logic b);
        pdm = b;
        if (b) m_acc++;
        if (m_bits == WIN - 1) begin
            if (m_warm) begin
                q.push_back('{conv(m_acc, DEC), cyc + CLK_DIV});
                last = conv(m_acc, DEC);
            end
            m_warm = 1'b1;
            m_acc = 0;
            m_bits = 0;
        end else begin
            m_bits++;
        end
        for (int i = 0; i < CLK_DIV; i++) begin
            @(negedge clk);
            check("mic_clk", mic, (i == 1 || i == 2));
            check("mic_clk_dec8", mic8, en8 ? (i == 1 || i == 2) : 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (valid) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", cyc, -1);
            end else begin
                e = q.pop_front();
                check("sample", sample, e.val);
                check("strobe_cycle", cyc, e.at);
            end
        end
        if (valid8) begin
            strobes8++;
            check("sample_dec8", sample8, conv(64, 8));
        end
    end

    initial begin
        rst_n = 1'b0;
        en = 1'b1;
        en8 = 1'b0;
        pdm = 1'b0;
        last = 0;
        model_reset();

        for (int i = 0; i < 10; i++) begin
            pdm = ~pdm;
            @(negedge clk);
            check("rst_mic", mic, 0);
            check("rst_sample", sample, 0);
            check("rst_valid", valid, 0);
        end

        pdm = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 2 * WIN; i++) send_bit(1'b1);
        for (int i = 0; i < WIN; i++) send_bit(1'b0);
        for (int i = 0; i < WIN; i++) send_bit(i % 2 == 0);
        for (int i = 0; i < WIN; i++) send_bit(i % 4 == 0);

        // Drop enable partway into a window.
        for (int i = 0; i < 30; i++) send_bit(1'b1);
        en = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_valid", valid, 0);
            check("idle_hold", sample, last);
        end
        en = 1'b1;
        for (int i = 0; i < WIN; i++) send_bit(1'b1);
        check("warmup_hold", sample, last);
        for (int i = 0; i < WIN; i++) send_bit(1'b1);

        // One-cycle reset pulse mid-window.
        for (int i = 0; i < 20; i++) send_bit(1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("pulse_sample", sample, 0);
        check("pulse_valid", valid, 0);
        last = 0;
        model_reset();
        for (int i = 0; i < WIN; i++) send_bit(i % 4 == 0);
        check("pulse_warmup_hold", sample, 0);
        for (int i = 0; i < WIN; i++) send_bit(i % 4 == 0);

        // Both instances start together; DEC_LOG2=8 sees 64 ones per 256 bits.
        en = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        en = 1'b1;
        en8 = 1'b1;
        for (int j = 0; j < 2 * 256 + 8; j++) send_bit(j % 4 == 0);
        en = 1'b0;
        en8 = 1'b0;
        repeat (3) @(negedge clk);
        check("dec8_strobes", strobes8, 1);
        check("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
